mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Iterative multiply/divide unit for the single-cycle/multi-cycle MIPS-style CPU.
- Consumes the two register-file read ports as operands and holds results in HI/LO.
- HI/LO feed the write-back mux, so MFHI/MFLO results go to the register-file write port.
- Provides a start/busy/done handshake so the controller can stall while an operation runs.

Parameters:
WIDTH, 32, operand/result width (HI and LO are each WIDTH bits)

Ports:
Clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO
is_signed  input  1  signed operation select (honoured only with SIGNED_MD_EN)
A  input  WIDTH  operand A (register-file port A data)
B  input  WIDTH  operand B (register-file port B data)
busy  output  1  operation in progress
done  output  1  one-cycle pulse when HI/LO have been updated by MULT/DIV
div_by_zero  output  1  valid with done; set when a DIV had B==0
HI  output  WIDTH  product high half / remainder
LO  output  WIDTH  product low half / quotient

Behaviour:
- Reset (sync, active-high) clears everything:
  - HI=0, LO=0, busy=0, done=0, div_by_zero=0.
  - State returns to IDLE; internal counter and work registers are cleared.
  - This applies mid-operation too; the partial result is discarded.
- States:
  - IDLE -> MUL (start, op=00).
  - IDLE -> DIV (start, op=01, B!=0).
  - IDLE -> DONE (start, op=01, B==0).
  - MUL/DIV -> DONE after WIDTH iterations.
  - DONE -> IDLE unconditionally.
- Operand capture:
  - A and B are latched at the edge that accepts start.
  - Later changes on A and B have no effect on the operation in flight.
- MULT: shift-add algorithm, one bit per cycle.
  - 2*WIDTH-bit product; HI = upper half, LO = lower half.
- DIV: restoring division, one quotient bit per cycle.
  - LO = quotient, HI = remainder.
- Timing:
  - busy=1 for exactly WIDTH cycles after the accepting edge.
  - On the next edge HI/LO are written, done=1 for one cycle and busy=0.
  - Latency from the start edge to done is WIDTH+1 cycles.
- Divide by zero:
  - No iterations; DONE is entered on the next edge with done=1 and div_by_zero=1.
  - HI and LO are left unchanged.
- div_by_zero is cleared on any other done pulse.
- MTHI/MTLO (start with op=10/11 in IDLE):
  - A is written to HI (or LO) at that edge.
  - No busy, no done; state stays IDLE.
- HI/LO hold their previous values throughout MUL/DIV; work registers are separate from HI/LO.
- start while busy, or in DONE: ignored, no queueing.
- is_signed is ignored without the macro; all MULT/DIV are then unsigned.

Optional Feature:
SIGNED_MD_EN
- Defined, when is_signed=1:
  - The magnitudes of A and B are taken at capture and the core runs unsigned.
  - At DONE, the product and quotient are negated when the operand signs differ.
  - The remainder takes the dividend's sign.
  - Latency is unchanged.
- Not defined: no sign logic is present and the is_signed port is unused.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MD_MULT/MD_DIV/MD_MTHI/MD_MTLO.
  - State encodings S_IDLE/S_MUL/S_DIV/S_DONE.
  - Default WIDTH constant.
- Single module; counter, datapath and FSM fit comfortably in one file.
- The sign pre/post-fixup is the only candidate to split out, as mdu_sign_fix under SIGNED_MD_EN.

Test Plan:
- MULT unsigned A=0xFFFFFFFF, B=0xFFFFFFFF -> busy cycles 1..32; done at cycle 33; HI=0xFFFFFFFE, LO=0x00000001.
- DIV unsigned A=100, B=7 -> after 33 cycles LO=14, HI=2, div_by_zero=0.
- DIV A=5, B=0 with HI=0xAA, LO=0xBB -> done next cycle, div_by_zero=1, HI=0xAA, LO=0xBB, busy never 1.
- MULT A=3, B=5; pulse start again at cycle 4 with op=01 -> second start ignored, LO=15.
  - Then a new MULT with reset at cycle 10 -> next cycle busy=0, HI=LO=0, state IDLE.
- MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 -> HI and LO updated one edge each; busy and done stay 0.
- SIGNED_MD_EN, is_signed=1:
  - -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - -3*5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - Without the macro, -3*5 unsigned -> HI=0x00000004, LO=0xFFFFFFF1.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - MD_* : operation encodings carried on the op port
//   - S_*  : FSM state encodings
//   - MDU_WIDTH : default operand/result width
package mdu_pkg;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [1:0] {
      MD_MULT = 2'b00,
      MD_DIV  = 2'b01,
      MD_MTHI = 2'b10,
      MD_MTLO = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_MUL  = 2'b01,
      S_DIV  = 2'b10,
      S_DONE = 2'b11
   } mdu_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// MULT uses shift-add and DIV uses restoring division, one bit per cycle,
// so an operation keeps busy high for WIDTH cycles and then pulses done.
// MTHI/MTLO write A straight into HI/LO in a single edge.
//
// Build option: define SIGNED_MD_EN to honour is_signed (sign-magnitude
// pre/post fixup around the unsigned core). Without it, is_signed is unused.
//
// Ports:
//   Clk         clock, all state updates on posedge
//   reset       synchronous active-high reset
//   start       request, sampled only in IDLE
//   op          00 MULT, 01 DIV, 10 MTHI, 11 MTLO
//   is_signed   signed operation select
//   A, B        operands (register-file read data)
//   busy        operation in progress
//   done        one-cycle pulse when MULT/DIV updated HI/LO
//   div_by_zero valid with done; the finished DIV had B == 0
//   HI, LO      product high/low half, or remainder/quotient
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   mdu_state_e       state_reg, state_next;
   logic [CW-1:0]    count_reg, count_next;
   // acc: running upper product half / partial remainder
   // q:   multiplier being shifted out / dividend shifted into quotient
   // b:   multiplicand / divisor
   logic [WIDTH-1:0] acc_reg, acc_next;
   logic [WIDTH-1:0] q_reg, q_next;
   logic [WIDTH-1:0] b_reg, b_next;
   logic [WIDTH-1:0] hi_reg, hi_next;
   logic [WIDTH-1:0] lo_reg, lo_next;
   logic             dbz_reg, dbz_next;

   logic             last_iter;

   // one shift-add step
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_acc, mul_q;

   // one restoring-division step
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_sub, div_acc, div_q;

   // operands as fed to the unsigned core, and results after sign fixup
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign last_iter = (count_reg == CW'(WIDTH - 1));

   assign mul_sum = {1'b0, acc_reg} + (q_reg[0] ? {1'b0, b_reg} : '0);
   assign mul_acc = mul_sum[WIDTH:1];
   assign mul_q   = {mul_sum[0], q_reg[WIDTH-1:1]};

   // The partial remainder is always below the divisor, so the shifted value
   // fits in WIDTH+1 bits and the difference, when taken, fits in WIDTH bits.
   assign div_shift = {acc_reg, q_reg[WIDTH-1]};
   assign div_ge    = (div_shift >= {1'b0, b_reg});
   assign div_sub   = div_shift[WIDTH-1:0] - b_reg;
   assign div_acc   = div_ge ? div_sub : div_shift[WIDTH-1:0];
   assign div_q     = {q_reg[WIDTH-2:0], div_ge};

`ifdef SIGNED_MD_EN
   logic neg_res_reg, neg_res_next;   // product / quotient gets negated
   logic neg_rem_reg, neg_rem_next;   // remainder follows dividend sign

   always_comb begin
      a_mag = (is_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
      b_mag = (is_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
   end

   always_comb begin
      prod_fix = neg_res_reg ? (~{mul_acc, mul_q} + 1'b1) : {mul_acc, mul_q};
      quo_fix  = neg_res_reg ? (~div_q + 1'b1) : div_q;
      rem_fix  = neg_rem_reg ? (~div_acc + 1'b1) : div_acc;
   end
`else
   logic unused_is_signed;
   assign unused_is_signed = is_signed;

   always_comb begin
      a_mag    = A;
      b_mag    = B;
      prod_fix = {mul_acc, mul_q};
      quo_fix  = div_q;
      rem_fix  = div_acc;
   end
`endif

   // Next-state and datapath control
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      acc_next   = acc_reg;
      q_next     = q_reg;
      b_next     = b_reg;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
      dbz_next   = dbz_reg;
`ifdef SIGNED_MD_EN
      neg_res_next = neg_res_reg;
      neg_rem_next = neg_rem_reg;
`endif

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               case (md_op_e'(op))
                  MD_MULT: begin
                     acc_next   = '0;
                     q_next     = b_mag;
                     b_next     = a_mag;
                     count_next = '0;
                     state_next = S_MUL;
`ifdef SIGNED_MD_EN
                     neg_res_next = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                     neg_rem_next = 1'b0;
`endif
                  end
                  MD_DIV: begin
                     if (B == '0) begin
                        // no iterations; HI/LO untouched
                        dbz_next   = 1'b1;
                        state_next = S_DONE;
                     end else begin
                        acc_next   = '0;
                        q_next     = a_mag;
                        b_next     = b_mag;
                        count_next = '0;
                        state_next = S_DIV;
`ifdef SIGNED_MD_EN
                        neg_res_next = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_rem_next = is_signed & A[WIDTH-1];
`endif
                     end
                  end
                  MD_MTHI: hi_next = A;
                  MD_MTLO: lo_next = A;
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            acc_next   = mul_acc;
            q_next     = mul_q;
            count_next = count_reg + 1'b1;
            if (last_iter) begin
               hi_next    = prod_fix[2*WIDTH-1:WIDTH];
               lo_next    = prod_fix[WIDTH-1:0];
               dbz_next   = 1'b0;
               state_next = S_DONE;
            end
         end
         S_DIV: begin
            acc_next   = div_acc;
            q_next     = div_q;
            count_next = count_reg + 1'b1;
            if (last_iter) begin
               hi_next    = rem_fix;
               lo_next    = quo_fix;
               dbz_next   = 1'b0;
               state_next = S_DONE;
            end
         end
         S_DONE: state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state_reg <= S_IDLE;
         count_reg <= '0;
         acc_reg   <= '0;
         q_reg     <= '0;
         b_reg     <= '0;
         hi_reg    <= '0;
         lo_reg    <= '0;
         dbz_reg   <= 1'b0;
`ifdef SIGNED_MD_EN
         neg_res_reg <= 1'b0;
         neg_rem_reg <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         acc_reg   <= acc_next;
         q_reg     <= q_next;
         b_reg     <= b_next;
         hi_reg    <= hi_next;
         lo_reg    <= lo_next;
         dbz_reg   <= dbz_next;
`ifdef SIGNED_MD_EN
         neg_res_reg <= neg_res_next;
         neg_rem_reg <= neg_rem_next;
`endif
      end
   end

   assign busy        = (state_reg == S_MUL) || (state_reg == S_DIV);
   assign done        = (state_reg == S_DONE);
   assign div_by_zero = dbz_reg;
   assign HI          = hi_reg;
   assign LO          = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32). Expected HI/LO/div_by_zero
// values are pushed to a scoreboard when an operation is issued and compared
// by a monitor when done pulses. Signed cases follow SIGNED_MD_EN.
module tb_mul_div_unit;
   import mdu_pkg::*;

   localparam int W = 32;

   logic         Clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic         is_signed;
   logic [W-1:0] A, B;
   logic         busy, done, div_by_zero;
   logic [W-1:0] HI, LO;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   done_seen = 0;
   int   done_expected = 0;

   mul_div_unit #(.WIDTH(W)) dut (
      .Clk(Clk), .reset(reset), .start(start), .op(op), .is_signed(is_signed),
      .A(A), .B(B), .busy(busy), .done(done), .div_by_zero(div_by_zero),
      .HI(HI), .LO(LO)
   );

   always #5 Clk = ~Clk;

   task automatic check_val(input string tag, input logic [63:0] actual,
                            input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // scoreboard monitor
   always @(negedge Clk) begin
      if (done) begin
         done_seen++;
         if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_val("HI", HI, e.hi);
            check_val("LO", LO, e.lo);
            check_val("div_by_zero", div_by_zero, e.dbz);
         end
      end
   end

   task automatic push_exp(input logic [W-1:0] eh, input logic [W-1:0] el,
                           input logic edbz);
      exp_t e;
      e.hi = eh; e.lo = el; e.dbz = edbz;
      sb_q.push_back(e);
      done_expected++;
   endtask

   // Issue MULT/DIV, scramble operands after capture, measure latency/busy.
   task automatic run_op(input logic [1:0] o, input logic sgn,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el,
                         input logic edbz, input int exp_cycles);
      int cycles;
      int busy_cnt;
      logic held;
      logic [W-1:0] hi0, lo0;
      @(negedge Clk);
      start = 1'b1; op = o; is_signed = sgn; A = a; B = b;
      push_exp(eh, el, edbz);
      $display("txn op=%0d signed=%0d A=0x%08h B=0x%08h", o, sgn, a, b);
      @(negedge Clk);
      start = 1'b0; A = $urandom; B = $urandom; is_signed = $urandom_range(0, 1);
      hi0 = HI; lo0 = LO;
      cycles = 1; busy_cnt = 0; held = 1'b1;
      while (!done && cycles < 200) begin
         if (busy) busy_cnt++;
         if (HI !== hi0 || LO !== lo0) held = 1'b0;
         @(negedge Clk);
         cycles++;
      end
      check_val("latency", cycles, exp_cycles);
      check_val("busy_cycles", busy_cnt, exp_cycles - 1);
      check_val("hilo_held", held, 1'b1);
      @(negedge Clk);
      check_val("done_pulse_1cyc", done, 1'b0);
   endtask

   task automatic mt_op(input logic [1:0] o, input logic [W-1:0] a);
      @(negedge Clk);
      start = 1'b1; op = o; A = a; B = $urandom;
      $display("txn op=%0d A=0x%08h", o, a);
      @(negedge Clk);
      start = 1'b0;
      check_val("mt_busy", busy, 1'b0);
      check_val("mt_done", done, 1'b0);
      if (o == MD_MTHI) check_val("mthi_HI", HI, a);
      else              check_val("mtlo_LO", LO, a);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] prod;
      logic [W-1:0] ra, rb;
      int cycles;

      reset = 1'b1; start = 1'b0; op = 2'b00; is_signed = 1'b0; A = '0; B = '0;
      repeat (3) @(negedge Clk);
      reset = 1'b0;
      check_val("rst_HI", HI, 0);
      check_val("rst_LO", LO, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_dbz", div_by_zero, 0);

      run_op(MD_MULT, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33);
      run_op(MD_DIV, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);

      mt_op(MD_MTHI, 32'hAA);
      mt_op(MD_MTLO, 32'hBB);
      run_op(MD_DIV, 1'b0, 32'd5, 32'd0, 32'hAA, 32'hBB, 1'b1, 1);

      // MULT 3*5 with a second start pulsed mid-operation (must be ignored);
      // also shows div_by_zero clearing on the next done
      @(negedge Clk);
      start = 1'b1; op = MD_MULT; is_signed = 1'b0; A = 32'd3; B = 32'd5;
      push_exp(32'd0, 32'd15, 1'b0);
      $display("txn op=0 A=0x00000003 B=0x00000005 (second start at cycle 4)");
      @(negedge Clk);
      start = 1'b0;
      repeat (2) @(negedge Clk);
      start = 1'b1; op = MD_DIV; A = 32'd100; B = 32'd7;
      @(negedge Clk);
      start = 1'b0;
      cycles = 4;
      while (!done && cycles < 200) begin
         @(negedge Clk);
         cycles++;
      end
      check_val("ignored_start_latency", cycles, 33);
      repeat (10) @(negedge Clk);
      check_val("ignored_start_idle", busy, 1'b0);

      // reset in the middle of a MULT
      @(negedge Clk);
      start = 1'b1; op = MD_MULT; A = 32'd9; B = 32'd9;
      $display("txn op=0 A=0x00000009 B=0x00000009 (reset at cycle 10)");
      @(negedge Clk);
      start = 1'b0;
      repeat (8) @(negedge Clk);
      reset = 1'b1;
      @(negedge Clk);
      reset = 1'b0;
      check_val("midrst_busy", busy, 1'b0);
      check_val("midrst_done", done, 1'b0);
      check_val("midrst_HI", HI, 0);
      check_val("midrst_LO", LO, 0);
      repeat (40) @(negedge Clk);
      check_val("midrst_still_idle", busy, 1'b0);

      mt_op(MD_MTHI, 32'h1234_5678);
      mt_op(MD_MTLO, 32'h9ABC_DEF0);
      check_val("mt_HI_kept", HI, 32'h1234_5678);

`ifdef SIGNED_MD_EN
      run_op(MD_MULT, 1'b1, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33);
      run_op(MD_DIV, 1'b1, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
`else
      run_op(MD_MULT, 1'b1, -32'sd3, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0, 33);
      run_op(MD_DIV, 1'b1, -32'sd7, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 33);
`endif

      // random unsigned operations against a 64-bit reference
      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom;
         prod = {32'd0, ra} * {32'd0, rb};
         run_op(MD_MULT, 1'b0, ra, rb, prod[63:32], prod[31:0], 1'b0, 33);
         if (i[0]) rb = rb >> $urandom_range(4, 28);
         if (rb == 0) rb = 32'd3;
         run_op(MD_DIV, 1'b0, ra, rb, ra % rb, ra / rb, 1'b0, 33);
      end

      repeat (3) @(negedge Clk);
      check_val("done_count", done_seen, done_expected);
      check_val("scoreboard_empty", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
